qtable_arbiter: RTL and testbench

- Sequences and shares the single-port Q-table RAM of the Q-learning datapath between two requesters: the learning agent (read-modify-write updates) and a host readout port (Q-table dump/print).
- Also runs a Q-table initialisation sweep on command, writing INIT_VALUE to every entry before training starts.
- Sits between the agent / control unit and the RAM macro.

---
 rtl/qtable_arbiter.sv | 170 +++++++++++++++++
 tb/tb_qtable_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtable_arbiter.sv
// qtable_arbiter
//   Shares the single-port Q-table RAM between the learning agent
//   (read-modify-write updates) and a read-only host readout port, and runs
//   an on-command initialisation sweep that writes INIT_VALUE to entries
//   0..DEPTH-1.
//
//   State table
//     state  | meaning
//     S_ARB  | normal arbitration between agent and host
//     S_INIT | init sweep, one RAM write per cycle, all grants held off
//
// Ports
//   clk, rst                         clock, async active-high reset
//   agent_req/we/addr/wdata/lock     agent access request; lock spans an RMW
//   agent_gnt/rvalid/rdata           agent grant and 1-cycle read return
//   host_req/addr                    host read request
//   host_gnt/rvalid/rdata            host grant and 1-cycle read return
//   init_start                       pulse requesting an init sweep
//   init_busy, init_done             sweep pending/running, end-of-sweep pulse
//   mem_en/we/addr/wdata, mem_rdata  RAM macro interface (sync read)
module qtable_arbiter #(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 16,
    parameter int                DEPTH        = 256,
    parameter int                STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              agent_req,
    input  logic              agent_we,
    input  logic [ADDR_W-1:0] agent_addr,
    input  logic [DATA_W-1:0] agent_wdata,
    input  logic              agent_lock,
    output logic              agent_gnt,
    output logic              agent_rvalid,
    output logic [DATA_W-1:0] agent_rdata,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_ARB,
        S_INIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pending;
    logic [ADDR_W-1:0] init_cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic              agent_rvalid_q;
    logic              host_rvalid_q;
    logic              init_done_q;
    logic              go_init;
    logic              agent_gnt_c;
    logic              host_gnt_c;

    // Outputs are gated with rst so that nothing is granted or driven onto
    // the RAM while reset is held, even if requesters keep req asserted.
    always_comb begin
        state_nxt   = state;
        go_init     = 1'b0;
        agent_gnt_c = 1'b0;
        host_gnt_c  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!rst) begin
            case (state)
                S_ARB: begin
                    if (pending && !agent_lock) begin
                        // transition cycle: no grant, sweep starts next cycle
                        go_init   = 1'b1;
                        state_nxt = S_INIT;
                    end else begin
                        host_gnt_c  = host_req &&
                                      (!agent_req ||
                                       (starve_cnt == STARVE_MAX && !agent_lock));
                        agent_gnt_c = agent_req && !host_gnt_c;
                        if (host_gnt_c) begin
                            mem_en   = 1'b1;
                            mem_addr = host_addr;
                        end else if (agent_gnt_c) begin
                            mem_en    = 1'b1;
                            mem_we    = agent_we;
                            mem_addr  = agent_addr;
                            mem_wdata = agent_wdata;
                        end
                    end
                end
                S_INIT: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = init_cnt;
                    mem_wdata = INIT_VALUE;
                    if (init_cnt == LAST_ADDR) begin
                        state_nxt = S_ARB;
                    end
                end
                default: state_nxt = S_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_ARB;
            pending        <= 1'b0;
            init_cnt       <= '0;
            starve_cnt     <= '0;
            agent_rvalid_q <= 1'b0;
            host_rvalid_q  <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state          <= state_nxt;
            init_done_q    <= (state == S_INIT) && (state_nxt == S_ARB);
            agent_rvalid_q <= agent_gnt_c && !agent_we;
            host_rvalid_q  <= host_gnt_c;

            // A start arriving in the transition cycle is covered by the
            // sweep that is about to begin, so the clear wins.
            if (go_init) begin
                pending <= 1'b0;
            end else if (state == S_ARB && init_start) begin
                pending <= 1'b1;
            end

            if (state == S_INIT) begin
                if (init_cnt == LAST_ADDR) begin
                    init_cnt <= '0;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end

            if (host_gnt_c || !host_req) begin
                starve_cnt <= '0;
            end else if (agent_gnt_c && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign agent_gnt    = agent_gnt_c;
    assign host_gnt     = host_gnt_c;
    assign agent_rvalid = agent_rvalid_q;
    assign host_rvalid  = host_rvalid_q;
    assign agent_rdata  = agent_rvalid_q ? mem_rdata : '0;
    assign host_rdata   = host_rvalid_q ? mem_rdata : '0;
    assign init_busy    = pending || (state == S_INIT);
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_qtable_arbiter.sv
module tb_qtable_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              agent_req, agent_we, agent_lock;
    logic [ADDR_W-1:0] agent_addr;
    logic [DATA_W-1:0] agent_wdata;
    logic              agent_gnt, agent_rvalid;
    logic [DATA_W-1:0] agent_rdata;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_gnt, host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              init_start, init_busy, init_done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    qtable_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT), .INIT_VALUE('0)
    ) dut (
        .clk(clk), .rst(rst),
        .agent_req(agent_req), .agent_we(agent_we), .agent_addr(agent_addr),
        .agent_wdata(agent_wdata), .agent_lock(agent_lock),
        .agent_gnt(agent_gnt), .agent_rvalid(agent_rvalid), .agent_rdata(agent_rdata),
        .host_req(host_req), .host_addr(host_addr),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro model: synchronous read, one-cycle latency.
    logic [DATA_W-1:0] ram  [0:DEPTH-1];
    logic [DATA_W-1:0] seed [0:DEPTH-1];
    logic [DATA_W-1:0] ram_q = '0;
    logic              preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= seed[i];
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Expected RAM contents, maintained from the bench's own view of traffic.
    logic [DATA_W-1:0] shadow [0:DEPTH-1];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [63:0] all_out();
        return {agent_gnt, agent_rvalid, agent_rdata, host_gnt, host_rvalid,
                host_rdata, init_busy, init_done, mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    task automatic drive_idle();
        agent_req = 0; agent_we = 0; agent_addr = '0; agent_wdata = '0;
        agent_lock = 0; host_req = 0; host_addr = '0; init_start = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        logic [11:0] act, exp;
        logic [16:0] ract, rexp;
        rst = 1;
        agent_req = 1; host_req = 1; agent_addr = 8'h40; host_addr = 8'h41;
        agent_we = 0; agent_wdata = '0; agent_lock = 0; init_start = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (all_out() !== 64'h0) begin
            n_err++; $display("FAIL reset_held: outputs %h expected 0", all_out());
        end
        drive_idle();
        rst = 0;
        #1;
        n_cmp++;
        if (all_out() !== 64'h0) begin
            n_err++; $display("FAIL reset_release: outputs %h expected 0", all_out());
        end
        @(negedge clk);
        agent_req = 1; agent_we = 0; agent_addr = 8'h12;
        #1;
        act = {agent_gnt, host_gnt, mem_en, mem_we, mem_addr};
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 8'h12};
        n_cmp++;
        if (act !== exp) begin
            n_err++; $display("FAIL first_read_grant: got %h expected %h", act, exp);
        end
        @(negedge clk);
        agent_req = 0;
        #1;
        ract = {agent_rvalid, agent_rdata};
        rexp = {1'b1, shadow[8'h12]};
        n_cmp++;
        if (ract !== rexp) begin
            n_err++; $display("FAIL first_read_data: got %h expected %h", ract, rexp);
        end
        @(negedge clk);
        agent_req = 1; agent_addr = 8'h05;
        @(posedge clk); #2;
        n_cmp++;
        if (agent_rvalid !== 1'b1) begin
            n_err++; $display("FAIL pre_async_rvalid: got %b expected 1", agent_rvalid);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (all_out() !== 64'h0) begin
            n_err++; $display("FAIL async_reset: outputs %h expected 0", all_out());
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_contention();
        logic [1:0] act, exp;
        logic       exp_h;
        logic [7:0] exp_a;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            agent_req = 1; host_req = 1; agent_lock = 0; agent_we = 0;
            agent_addr = 8'h20 + 8'(k); host_addr = 8'h80 + 8'(k);
            #1;
            // host is forced in after every LIMIT consecutive agent wins
            exp_h = (k % (LIMIT + 1)) == 0;
            exp   = {~exp_h, exp_h};
            act   = {agent_gnt, host_gnt};
            exp_a = exp_h ? host_addr : agent_addr;
            n_cmp++;
            if (act !== exp || mem_addr !== exp_a) begin
                n_err++;
                $display("FAIL contention_c%0d: gnt %b addr %h expected gnt %b addr %h",
                         k, act, mem_addr, exp, exp_a);
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] act;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            agent_req = 1; host_req = 1; agent_lock = 1; agent_we = 0;
            agent_addr = 8'h30; host_addr = 8'h31;
            #1;
            act = {agent_gnt, host_gnt};
            n_cmp++;
            if (act !== 2'b10) begin
                n_err++; $display("FAIL lock_c%0d: gnt %b expected 10", k, act);
            end
        end
        @(negedge clk);
        agent_lock = 0;
        #1;
        act = {agent_gnt, host_gnt};
        n_cmp++;
        if (act !== 2'b01) begin
            n_err++; $display("FAIL lock_release: gnt %b expected 01", act);
        end
        @(negedge clk);
        #1;
        act = {agent_gnt, host_gnt};
        n_cmp++;
        if (act !== 2'b10) begin
            n_err++; $display("FAIL lock_regain: gnt %b expected 10", act);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d;
        logic [16:0]       act, exp;
        do_reset();
        d = 16'($urandom);
        @(negedge clk);
        agent_req = 1; agent_we = 1; agent_addr = 8'h77; agent_wdata = d;
        @(negedge clk);
        agent_we = 0;
        @(negedge clk);
        agent_req = 0; host_req = 1; host_addr = 8'h77;
        #1;
        shadow[8'h77] = d;
        act = {agent_rvalid, agent_rdata};
        exp = {1'b1, d};
        n_cmp++;
        if (act !== exp) begin
            n_err++; $display("FAIL rmw_agent_read: got %h expected %h", act, exp);
        end
        @(negedge clk);
        host_req = 0;
        #1;
        act = {host_rvalid, host_rdata};
        n_cmp++;
        if (act !== exp) begin
            n_err++; $display("FAIL rmw_host_read: got %h expected %h", act, exp);
        end
    endtask

    task automatic test_random();
        int                waits;
        logic              eh, ea;
        logic              p_arv, p_hrv;
        logic [DATA_W-1:0] p_ard, p_hrd;
        logic [25:0]       mact, mexp;
        logic [33:0]       ract, rexp;
        do_reset();
        waits = 0; p_arv = 0; p_hrv = 0; p_ard = '0; p_hrd = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            agent_req   = ($urandom % 4) != 0;
            host_req    = ($urandom % 2) == 1;
            agent_lock  = ($urandom % 4) == 0;
            agent_we    = ($urandom % 2) == 1;
            agent_addr  = 8'($urandom % 16);
            host_addr   = 8'($urandom % 16);
            agent_wdata = 16'($urandom);
            eh = host_req && (!agent_req || (waits >= LIMIT && !agent_lock));
            ea = agent_req && !eh;
            #1;
            n_cmp++;
            if ({agent_gnt, host_gnt} !== {ea, eh}) begin
                n_err++;
                $display("FAIL rand_gnt c%0d: gnt %b%b expected %b%b",
                         c, agent_gnt, host_gnt, ea, eh);
            end
            mexp = {ea | eh, ea & agent_we,
                    eh ? host_addr : (ea ? agent_addr : 8'h00),
                    (ea & agent_we) ? agent_wdata : 16'h0};
            mact = {mem_en, mem_we, mem_en ? mem_addr : 8'h00,
                    mem_we ? mem_wdata : 16'h0};
            n_cmp++;
            if (mact !== mexp) begin
                n_err++; $display("FAIL rand_mem c%0d: got %h expected %h", c, mact, mexp);
            end
            rexp = {p_arv, p_arv ? p_ard : 16'h0, p_hrv, p_hrv ? p_hrd : 16'h0};
            ract = {agent_rvalid, agent_rdata, host_rvalid, host_rdata};
            n_cmp++;
            if (ract !== rexp) begin
                n_err++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, ract, rexp);
            end
            p_arv = ea && !agent_we;
            p_ard = shadow[agent_addr];
            p_hrv = eh;
            p_hrd = shadow[host_addr];
            if (ea && agent_we) shadow[agent_addr] = agent_wdata;
            if (!host_req || eh) waits = 0;
            else if (ea)         waits++;
        end
    endtask

    task automatic test_init();
        logic [29:0] act, exp;
        logic [2:0]  a3;
        logic [17:0] r18;
        do_reset();
        @(negedge clk);
        init_start = 1;
        #1;
        n_cmp++;
        if (init_busy !== 1'b0) begin
            n_err++; $display("FAIL init_busy_early: got %b expected 0", init_busy);
        end
        @(negedge clk);
        init_start = 0;
        agent_req = 1; agent_we = 0; agent_addr = 8'h33;
        host_req = 1; host_addr = 8'h44;
        #1;
        a3 = {init_busy, agent_gnt | host_gnt, mem_en};
        n_cmp++;
        if (a3 !== 3'b100) begin
            n_err++; $display("FAIL init_transition: busy/gnt/en %b expected 100", a3);
        end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            #1;
            act = {mem_en, mem_we, mem_addr, mem_wdata, agent_gnt, host_gnt, init_busy, init_done};
            exp = {1'b1, 1'b1, 8'(i), 16'h0, 1'b0, 1'b0, 1'b1, 1'b0};
            n_cmp++;
            if (act !== exp) begin
                n_err++; $display("FAIL init_write_%0d: got %h expected %h", i, act, exp);
            end
            shadow[i] = '0;
        end
        @(negedge clk);
        #1;
        a3 = {init_done, init_busy, agent_gnt};
        n_cmp++;
        if (a3 !== 3'b101 || host_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL init_done_pulse: done/busy/agnt %b hgnt %b expected 101 0", a3, host_gnt);
        end
        @(negedge clk);
        agent_req = 0; host_addr = 8'hFF;
        #1;
        r18 = {init_done, host_gnt, agent_rvalid, agent_rdata[14:0]};
        n_cmp++;
        if (r18 !== {3'b011, 15'h0} || agent_rdata !== 16'h0) begin
            n_err++; $display("FAIL init_after: got %h expected %h", r18, {3'b011, 15'h0});
        end
        @(negedge clk);
        host_req = 0;
        #1;
        n_cmp++;
        if ({host_rvalid, host_rdata} !== {1'b1, shadow[8'hFF]}) begin
            n_err++;
            $display("FAIL init_host_read: got %b %h expected 1 %h", host_rvalid, host_rdata, shadow[8'hFF]);
        end
    endtask

    task automatic test_init_deferral();
        logic [2:0] a3;
        do_reset();
        @(negedge clk);
        agent_req = 1; agent_we = 0; agent_addr = 8'h10; agent_lock = 1; init_start = 1;
        #1;
        n_cmp++;
        if (agent_gnt !== 1'b1) begin
            n_err++; $display("FAIL defer_start_gnt: got %b expected 1", agent_gnt);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            init_start = 0;
            #1;
            a3 = {agent_gnt, init_busy, mem_we};
            n_cmp++;
            if (a3 !== 3'b110) begin
                n_err++; $display("FAIL defer_hold_%0d: gnt/busy/we %b expected 110", k, a3);
            end
        end
        @(negedge clk);
        agent_lock = 0;
        #1;
        a3 = {agent_gnt, init_busy, mem_en};
        n_cmp++;
        if (a3 !== 3'b010) begin
            n_err++; $display("FAIL defer_unlock: gnt/busy/en %b expected 010", a3);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, agent_gnt} !== {2'b11, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL defer_sweep_start: en/we %b%b addr %h gnt %b expected 11 00 0",
                     mem_en, mem_we, mem_addr, agent_gnt);
        end
        // reset lands before the clock edge, so address 0 is not written
        do_reset();
    endtask

    task automatic test_reset_mid_sweep();
        int   done_seen;
        logic ok;
        do_reset();
        @(negedge clk);
        init_start = 1;
        @(negedge clk);
        init_start = 0;
        ok = 1;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_addr !== 8'(i) || mem_we !== 1'b1) ok = 0;
            if (i < 100) shadow[i] = '0;
        end
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL midsweep_reach100: addr %h we %b expected 64 1", mem_addr, mem_we);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (all_out() !== 64'h0) begin
            n_err++; $display("FAIL midsweep_abort: outputs %h expected 0", all_out());
        end
        @(negedge clk);
        rst = 0;
        agent_req = 1; agent_we = 0; agent_addr = 8'd150;
        #1;
        n_cmp++;
        if ({agent_gnt, init_busy, init_done} !== 3'b100) begin
            n_err++;
            $display("FAIL midsweep_grant: gnt/busy/done %b%b%b expected 100", agent_gnt, init_busy, init_done);
        end
        @(negedge clk);
        agent_req = 0;
        #1;
        n_cmp++;
        if ({agent_rvalid, agent_rdata} !== {1'b1, shadow[150]}) begin
            n_err++;
            $display("FAIL midsweep_read: got %b %h expected 1 %h", agent_rvalid, agent_rdata, shadow[150]);
        end
        done_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (init_done !== 1'b0 || init_busy !== 1'b0) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_err++; $display("FAIL midsweep_no_done: saw %0d busy/done cycles expected 0", done_seen);
        end
    endtask

    initial begin
        rst = 1;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) begin
            seed[i]   = 16'($urandom);
            shadow[i] = seed[i];
        end
        preload = 1;
        @(posedge clk);
        #1;
        preload = 0;
        test_reset();
        test_contention();
        test_lock();
        test_back_to_back();
        test_random();
        test_init();
        test_init_deferral();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
